// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare predictor and its resolution unit.
package bp_pkg;

  localparam int unsigned BP_XLEN     = 32;
  localparam int unsigned BP_IDX_BITS = 8;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [BP_XLEN-1:0] pc;
    logic               taken;
    logic [BP_XLEN-1:0] target;
  } entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Prediction, resolution and training/redirect signals of the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = 8,
  parameter int unsigned CNT_BITS = 16
);

  logic                pred_valid;
  logic [XLEN-1:0]     pred_pc;
  logic                pred_taken;
  logic [XLEN-1:0]     pred_target;
  logic                res_valid;
  logic                res_is_cond;
  logic                res_taken;
  logic [XLEN-1:0]     res_target;
  logic                flush;
  logic [XLEN-1:0]     redirect_pc;
  logic                update;
  logic [IDX_BITS-1:0] update_address;
  logic                branch_taken;
  logic                q_full;
  logic                q_empty;
  logic [CNT_BITS-1:0] mispredict_cnt;
  logic [1:0]          err;

  // Pipeline side: drives predictions and resolutions, consumes redirect/training.
  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_is_cond, res_taken, res_target,
    input  flush, redirect_pc, update, update_address, branch_taken,
    input  q_full, q_empty, mispredict_cnt, err
  );

  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_is_cond, res_taken, res_target,
    output flush, redirect_pc, update, update_address, branch_taken,
    output q_full, q_empty, mispredict_cnt, err
  );

endinterface

// File: rtl/bp_inflight_fifo.sv
// In-order queue of in-flight predictions; clear wins over push and pop.
module bp_inflight_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem[rptr_q];
  // A pop frees the slot in the same cycle, so push-while-full is legal alongside it.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks resolved branches against queued predictions; drives flush/redirect and BHT/GHR training.
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned XLEN     = BP_XLEN,
  parameter int unsigned IDX_BITS = BP_IDX_BITS,
  parameter int unsigned CNT_BITS = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_resolve_unit_if.slave  bus
);

  entry_t head, wentry;
  logic   full, empty;
  logic   pop, mispredict, flush_d;

  logic                flush_q;
  logic [XLEN-1:0]     redirect_q, redirect_d;
  logic                update_q;
  logic [IDX_BITS-1:0] addr_q;
  logic                taken_q;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          err_q, err_d;

  assign wentry = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};

  bp_inflight_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush_d),
    .push  (bus.pred_valid && !flush_d),
    .pop   (pop),
    .wdata (wentry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign pop        = bus.res_valid && !empty;
  assign mispredict = (head.taken != bus.res_taken) ||
                      (bus.res_taken && (head.target != bus.res_target));
  assign flush_d    = pop && mispredict;

  always_comb begin
    redirect_d = redirect_q;
    if (flush_d) redirect_d = bus.res_taken ? bus.res_target : head.pc + XLEN'(4);
    cnt_d = cnt_q;
    if (flush_d && !(&cnt_q)) cnt_d = cnt_q + CNT_BITS'(1);
    // A push on a flush cycle is wrong-path, not an overflow.
    err_d = err_q | {bus.res_valid && empty, bus.pred_valid && full && !pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      update_q   <= 1'b0;
      addr_q     <= '0;
      taken_q    <= 1'b0;
      cnt_q      <= '0;
      err_q      <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      update_q   <= pop && bus.res_is_cond;
      if (pop && bus.res_is_cond) begin
        addr_q  <= head.pc[IDX_BITS-1:0];
        taken_q <= bus.res_taken;
      end
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.flush          = flush_q;
  assign bus.redirect_pc    = redirect_q;
  assign bus.update         = update_q;
  assign bus.update_address = addr_q;
  assign bus.branch_taken   = taken_q;
  assign bus.q_full         = full;
  assign bus.q_empty        = empty;
  assign bus.mispredict_cnt = cnt_q;
  assign bus.err            = err_q;

endmodule
